// File: rtl/ashift_norm.sv
// rtl/ashift_norm.sv - signed operand normalizer: shifts out redundant sign bits, reports shift count
// Optional ASHIFT_NORM_STRIDE2_EN: two-bit steps while at least two redundant sign bits remain.
module ashift_norm #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [4:0]       out_shift
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] CNT_MAX = 5'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [4:0]       count_q, count_d;

   logic             top2_eq;
   logic             top3_eq;

   assign top2_eq = (data_q[WIDTH-1] == data_q[WIDTH-2]);
   assign top3_eq = top2_eq && (data_q[WIDTH-2] == data_q[WIDTH-3]);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               count_d = 5'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
`ifdef ASHIFT_NORM_STRIDE2_EN
            // Double step only when the single-step rule would fire twice in a row.
            if (top3_eq && (count_q <= CNT_MAX - 5'd2)) begin
               data_d  = data_q << 2;
               count_d = count_q + 5'd2;
            end else
`endif
            if (top2_eq && (count_q < CNT_MAX)) begin
               data_d  = data_q << 1;
               count_d = count_q + 5'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         count_q <= 5'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = data_q;
   assign out_shift = count_q;

   logic unused_top3;
   assign unused_top3 = top3_eq;

endmodule

// File: doc/ashift_norm.md
ASHIFT_NORM -- requirements
Module: ashift_norm

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of the signed operand (legal 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port in_data  input  WIDTH  signed operand to normalize.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  downstream accepts result.
REQ-009 SHALL have port out_data  output  WIDTH  signed normalized value (in_data <<< N).
REQ-010 SHALL have port out_shift  output  5  left-shift count N applied; undoing it needs out_data >>> N.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept an operand on a clock edge with in_valid & in_ready, loading data register and clearing count, IDLE -> SHIFT.
REQ-013 In SHIFT, each edge: if data[WIDTH-1] == data[WIDTH-2] and count < WIDTH-1, data <= data <<< 1 (zero fill), count <= count + 1, stay SHIFT; else -> DONE, registers held.
REQ-014 SHALL yield N = number of redundant sign bits, capped at WIDTH-1; out_valid rises N+1 edges after the accepting edge.
REQ-015 Zero operand SHALL give out_data 0, out_shift WIDTH-1; all-ones operand SHALL give out_data = most negative value, out_shift WIDTH-1.
REQ-016 Already-normalized operand (top two bits differ) SHALL give N = 0, out_data = in_data.
REQ-017 In DONE, out_data/out_shift SHALL stay stable while out_ready = 0; on out_valid & out_ready, DONE -> IDLE.
REQ-018 No new operand SHALL be accepted in the same edge a result is consumed (in_ready rises the cycle after).
REQ-019 in_data SHALL be ignored outside IDLE; in_valid held high during SHIFT/DONE has no effect.
REQ-020 out_shift width SHALL be 5 regardless of WIDTH; upper unused bits zero.

Reset
REQ-021 rst high on an edge SHALL force IDLE, out_valid 0, in_ready 1 after the edge, out_data 0, out_shift 0.
REQ-022 rst SHALL take priority over any handshake in the same edge; an in-flight operand is discarded with no output.
REQ-023 All state SHALL be reset; no X on any output after the first reset edge.

Configuration
REQ-024 Macro ASHIFT_NORM_STRIDE2_EN defined: in SHIFT, if top three bits equal and count <= WIDTH-3, shift by 2 and count += 2 in one edge; else REQ-013 single-step rule applies.
REQ-025 With ASHIFT_NORM_STRIDE2_EN, out_data/out_shift SHALL be bit-identical to the undefined build; only latency shrinks (steps = ceil-compatible sequence of 2-then-1 shifts, plus one terminating edge).
REQ-026 Macro undefined: single-bit stride only, latency exactly N+1 edges per REQ-014.

Verification (WIDTH = 16, macro undefined unless stated)
REQ-027 in_data 0x0001 -> out_data 0x4000, out_shift 14, out_valid 15 edges after accept.
REQ-028 in_data 0xFFF0 -> out_data 0x8000, out_shift 11; 0xFFFF -> 0x8000, shift 15; 0x0000 -> 0x0000, shift 15.
REQ-029 in_data 0x4000 -> out_data 0x4000, out_shift 0, out_valid 1 edge after accept.
REQ-030 Hold out_ready 0 for 5 cycles in DONE -> outputs stable, in_ready 0; raise out_ready -> IDLE next edge, in_ready 1.
REQ-031 Assert rst 3 edges into shifting 0x0001 -> IDLE, out_valid never rises, next operand 0x2000 yields shift 1, out_data 0x4000.
REQ-032 ASHIFT_NORM_STRIDE2_EN, in_data 0x0001 -> out_data 0x4000, shift 14, out_valid 8 edges after accept.
